// File: rtl/dekatron_chain.sv
// Multi-digit one-hot counter built from dekatron-style ring digits with
// forward/reverse stepping, one-hot loading and a rippling or instant carry chain.
module dekatron_chain #(
   parameter int DIGITS = 4,
   parameter int RADIX  = 10,
   parameter int RIPPLE = 1
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   Request,
   input  logic                   Set,
   input  logic                   Reverse,
   input  logic [DIGITS*10-1:0]   In,
   output logic [DIGITS*10-1:0]   Out,
   output logic                   Ready,
   output logic                   Zero,
   output logic                   Overflow
);

   localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [RADIX-1:0] POS0 = RADIX'(1);

   typedef enum logic {IDLE, CARRY} state_t;

   state_t                        state_reg, state_next;
   logic [DIGITS-1:0][RADIX-1:0]  digit_reg, digit_next;
   logic [PW-1:0]                 ptr_reg, ptr_next;
   logic                          dir_reg, dir_next;
   logic                          ready_reg;
   logic                          overflow_reg, overflow_next;

   logic [DIGITS-1:0][RADIX-1:0]  load_val, step_val, carry_val;
   logic [DIGITS-1:0]             wrap_here, all_thru, rot_en;
   logic [DIGITS-1:0]             digit_zero;

   function automatic logic [RADIX-1:0] rot(input logic [RADIX-1:0] d, input logic rev);
      if (rev)
         return {d[0], d[RADIX-1:1]};
      else
         return {d[RADIX-2:0], d[RADIX-1]};
   endfunction

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [9:0] field;
         logic       valid;
         assign field = In[10*gi +: 10];
         // Only a single bit inside the ring is a legal position; anything else loads 0.
         assign valid = (field != 10'd0) && ((field & (field - 10'd1)) == 10'd0)
                        && ((field >> RADIX) == 10'd0);
         assign load_val[gi]  = valid ? field[RADIX-1:0] : POS0;
         assign step_val[gi]  = rot(digit_reg[gi], Reverse);
         assign carry_val[gi] = rot(digit_reg[gi], dir_reg);
         assign wrap_here[gi] = Reverse ? digit_reg[gi][0] : digit_reg[gi][RADIX-1];
         assign all_thru[gi]  = &wrap_here[gi:0];
         assign digit_zero[gi] = (digit_reg[gi] == POS0);
         assign Out[10*gi +: 10] = 10'(digit_reg[gi]);
         if (gi == 0) begin : g_lsd
            assign rot_en[gi] = 1'b1;
         end else begin : g_upper
            assign rot_en[gi] = all_thru[gi-1];
         end
      end
   endgenerate

   assign Zero     = &digit_zero;
   assign Ready    = ready_reg;
   assign Overflow = overflow_reg;

   always_comb begin
      state_next    = state_reg;
      digit_next    = digit_reg;
      ptr_next      = ptr_reg;
      dir_next      = dir_reg;
      overflow_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (Request) begin
               if (Set) begin
                  digit_next = load_val;
               end else if (RIPPLE == 0 || DIGITS == 1) begin
                  // Instant carry: every digit whose lower digits all wrap steps now.
                  for (int d = 0; d < DIGITS; d++)
                     if (rot_en[d]) digit_next[d] = step_val[d];
                  overflow_next = all_thru[DIGITS-1];
               end else begin
                  digit_next[0] = step_val[0];
                  if (wrap_here[0]) begin
                     dir_next   = Reverse;
                     ptr_next   = PW'(1);
                     state_next = CARRY;
                  end
               end
            end
         end
         CARRY: begin
            digit_next[ptr_reg] = carry_val[ptr_reg];
            if (dir_reg ? digit_reg[ptr_reg][0] : digit_reg[ptr_reg][RADIX-1]) begin
               if (ptr_reg == PW'(DIGITS-1)) begin
                  overflow_next = 1'b1;
                  state_next    = IDLE;
               end else begin
                  ptr_next = ptr_reg + PW'(1);
               end
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_reg    <= IDLE;
         for (int d = 0; d < DIGITS; d++) digit_reg[d] <= POS0;
         ptr_reg      <= '0;
         dir_reg      <= 1'b0;
         ready_reg    <= 1'b1;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         digit_reg    <= digit_next;
         ptr_reg      <= ptr_next;
         dir_reg      <= dir_next;
         ready_reg    <= (state_next == IDLE);
         overflow_reg <= overflow_next;
      end
   end

endmodule

// File: tb/tb_dekatron_chain.sv
// Directed bench for dekatron_chain: decimal rippling, octal rippling and
// decimal instant-carry instances share one clock and reset.
module tb_dekatron_chain;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // a: DIGITS=4 RADIX=10 RIPPLE=1
   logic a_req = 0, a_set = 0, a_rev = 0;
   logic [39:0] a_in = '0, a_out;
   logic a_ready, a_zero, a_ovf;
   // b: DIGITS=2 RADIX=8 RIPPLE=1
   logic b_req = 0, b_set = 0, b_rev = 0;
   logic [19:0] b_in = '0, b_out;
   logic b_ready, b_zero, b_ovf;
   // c: DIGITS=4 RADIX=10 RIPPLE=0
   logic c_req = 0, c_set = 0, c_rev = 0;
   logic [39:0] c_in = '0, c_out;
   logic c_ready, c_zero, c_ovf;

   dekatron_chain #(.DIGITS(4), .RADIX(10), .RIPPLE(1)) u_dec (
      .Clk(clk), .Rst_n(rst_n), .Request(a_req), .Set(a_set), .Reverse(a_rev),
      .In(a_in), .Out(a_out), .Ready(a_ready), .Zero(a_zero), .Overflow(a_ovf));

   dekatron_chain #(.DIGITS(2), .RADIX(8), .RIPPLE(1)) u_oct (
      .Clk(clk), .Rst_n(rst_n), .Request(b_req), .Set(b_set), .Reverse(b_rev),
      .In(b_in), .Out(b_out), .Ready(b_ready), .Zero(b_zero), .Overflow(b_ovf));

   dekatron_chain #(.DIGITS(4), .RADIX(10), .RIPPLE(0)) u_nr (
      .Clk(clk), .Rst_n(rst_n), .Request(c_req), .Set(c_set), .Reverse(c_rev),
      .In(c_in), .Out(c_out), .Ready(c_ready), .Zero(c_zero), .Overflow(c_ovf));

   function automatic logic [39:0] dec4(input int v);
      logic [39:0] r;
      int x;
      r = '0;
      x = v;
      for (int d = 0; d < 4; d++) begin
         r[10*d +: 10] = 10'd1 << (x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [19:0] oct2(input int v);
      logic [19:0] r;
      r[9:0]   = 10'd1 << (v % 8);
      r[19:10] = 10'd1 << ((v / 8) % 8);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_load(input int v);
      a_req = 1; a_set = 1; a_in = dec4(v);
      tick();
      a_req = 0; a_set = 0;
      checks++;
      if (a_out !== dec4(v)) begin
         $display("FAIL a_load %0d: out=%h expected %h", v, a_out, dec4(v)); fails++;
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      tick();
      $display("reset: a_out=%h b_out=%h c_out=%h", a_out, b_out, c_out);
      checks += 6;
      if (a_out !== dec4(0)) begin $display("FAIL reset_out: got %h expected %h", a_out, dec4(0)); fails++; end
      if (a_ready !== 1'b1) begin $display("FAIL reset_ready: got %b expected 1", a_ready); fails++; end
      if (a_zero !== 1'b1) begin $display("FAIL reset_zero: got %b expected 1", a_zero); fails++; end
      if (a_ovf !== 1'b0) begin $display("FAIL reset_ovf: got %b expected 0", a_ovf); fails++; end
      if (b_out !== oct2(0)) begin $display("FAIL reset_oct_out: got %h expected %h", b_out, oct2(0)); fails++; end
      if (c_out !== dec4(0)) begin $display("FAIL reset_nr_out: got %h expected %h", c_out, dec4(0)); fails++; end
      rst_n = 1;
   endtask

   task automatic test_ripple();
      int exp_v[3] = '{190, 100, 200};
      logic exp_r[3] = '{1'b0, 1'b0, 1'b1};
      int low = 0;
      a_load(199);
      a_req = 1; a_set = 0; a_rev = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         a_req = 0;
         if (!a_ready) low++;
         $display("ripple edge%0d: out=%h ready=%b ovf=%b", i + 1, a_out, a_ready, a_ovf);
         checks += 3;
         if (a_out !== dec4(exp_v[i])) begin $display("FAIL ripple_out edge%0d: got %h expected %h", i + 1, a_out, dec4(exp_v[i])); fails++; end
         if (a_ready !== exp_r[i]) begin $display("FAIL ripple_ready edge%0d: got %b expected %b", i + 1, a_ready, exp_r[i]); fails++; end
         if (a_ovf !== 1'b0) begin $display("FAIL ripple_ovf edge%0d: got %b expected 0", i + 1, a_ovf); fails++; end
      end
      checks++;
      if (low != 2) begin $display("FAIL ripple_ready_low_cycles: got %0d expected 2", low); fails++; end
   endtask

   task automatic run_wrap(input logic rev, input int exp_v[4], input string tag);
      a_req = 1; a_set = 0; a_rev = rev;
      for (int i = 0; i < 4; i++) begin
         tick();
         a_req = 0;
         $display("%s edge%0d: out=%h ready=%b ovf=%b zero=%b", tag, i + 1, a_out, a_ready, a_ovf, a_zero);
         checks += 3;
         if (a_out !== dec4(exp_v[i])) begin $display("FAIL %s_out edge%0d: got %h expected %h", tag, i + 1, a_out, dec4(exp_v[i])); fails++; end
         if (a_ready !== (i == 3)) begin $display("FAIL %s_ready edge%0d: got %b expected %b", tag, i + 1, a_ready, i == 3); fails++; end
         if (a_ovf !== (i == 3)) begin $display("FAIL %s_ovf edge%0d: got %b expected %b", tag, i + 1, a_ovf, i == 3); fails++; end
      end
      tick();
      checks++;
      if (a_ovf !== 1'b0) begin $display("FAIL %s_ovf_pulse: got %b expected 0", tag, a_ovf); fails++; end
   endtask

   task automatic test_full_wrap();
      a_load(9999);
      run_wrap(1'b0, '{9990, 9900, 9000, 0}, "wrap_fwd");
      checks++;
      if (a_zero !== 1'b1) begin $display("FAIL wrap_fwd_zero: got %b expected 1", a_zero); fails++; end
      run_wrap(1'b1, '{9, 99, 999, 9999}, "wrap_rev");
      checks++;
      if (a_zero !== 1'b0) begin $display("FAIL wrap_rev_zero: got %b expected 0", a_zero); fails++; end
   endtask

   task automatic test_octal();
      b_req = 1; b_set = 1; b_in = oct2(63);
      tick();
      b_set = 0; b_rev = 0;
      tick();
      b_req = 0;
      $display("octal step edge1: out=%h ready=%b ovf=%b", b_out, b_ready, b_ovf);
      checks += 2;
      if (b_out !== oct2(56)) begin $display("FAIL oct_step1_out: got %h expected %h", b_out, oct2(56)); fails++; end
      if (b_ready !== 1'b0) begin $display("FAIL oct_step1_ready: got %b expected 0", b_ready); fails++; end
      tick();
      $display("octal step edge2: out=%h ready=%b ovf=%b", b_out, b_ready, b_ovf);
      checks += 3;
      if (b_out !== oct2(0)) begin $display("FAIL oct_wrap_out: got %h expected %h", b_out, oct2(0)); fails++; end
      if (b_ovf !== 1'b1) begin $display("FAIL oct_wrap_ovf: got %b expected 1", b_ovf); fails++; end
      if (b_zero !== 1'b1) begin $display("FAIL oct_wrap_zero: got %b expected 1", b_zero); fails++; end
      // Illegal digit-0 codes load position 0; digit 1 = position 2 is kept.
      b_req = 1; b_set = 1; b_in = {10'h004, 10'h200};
      tick();
      $display("octal load bit9: out=%h", b_out);
      checks++;
      if (b_out !== {10'h004, 10'h001}) begin $display("FAIL oct_load_bit9: got %h expected %h", b_out, {10'h004, 10'h001}); fails++; end
      b_in = {10'h100, 10'h003};
      tick();
      $display("octal load bad: out=%h", b_out);
      checks++;
      if (b_out !== oct2(0)) begin $display("FAIL oct_load_bad: got %h expected %h", b_out, oct2(0)); fails++; end
      b_set = 0; b_rev = 1;
      tick();
      b_req = 0;
      $display("octal rev edge1: out=%h ready=%b", b_out, b_ready);
      checks++;
      if (b_out !== oct2(7)) begin $display("FAIL oct_rev1_out: got %h expected %h", b_out, oct2(7)); fails++; end
      tick();
      $display("octal rev edge2: out=%h ready=%b ovf=%b", b_out, b_ready, b_ovf);
      checks += 3;
      if (b_out !== oct2(63)) begin $display("FAIL oct_rev_out: got %h expected %h", b_out, oct2(63)); fails++; end
      if (b_ovf !== 1'b1) begin $display("FAIL oct_rev_ovf: got %b expected 1", b_ovf); fails++; end
      if (b_ready !== 1'b1) begin $display("FAIL oct_rev_ready: got %b expected 1", b_ready); fails++; end
   endtask

   task automatic test_noripple();
      int start_v[3] = '{999, 9999, 1000};
      int exp_v[3]   = '{1000, 0, 999};
      logic rev_v[3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         c_req = 1; c_set = 1; c_in = dec4(start_v[i]);
         tick();
         c_set = 0; c_rev = rev_v[i];
         tick();
         c_req = 0;
         $display("noripple %0d rev=%b: out=%h ready=%b ovf=%b", start_v[i], rev_v[i], c_out, c_ready, c_ovf);
         checks += 3;
         if (c_out !== dec4(exp_v[i])) begin $display("FAIL nr_out %0d: got %h expected %h", start_v[i], c_out, dec4(exp_v[i])); fails++; end
         if (c_ready !== 1'b1) begin $display("FAIL nr_ready %0d: got %b expected 1", start_v[i], c_ready); fails++; end
         if (c_ovf !== (i == 1)) begin $display("FAIL nr_ovf %0d: got %b expected %b", start_v[i], c_ovf, i == 1); fails++; end
      end
   endtask

   task automatic test_back_to_back();
      a_load(5);
      a_req = 1; a_set = 0; a_rev = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         $display("b2b fwd %0d: out=%h ready=%b", i, a_out, a_ready);
         checks += 2;
         if (a_out !== dec4(6 + i)) begin $display("FAIL b2b_out %0d: got %h expected %h", i, a_out, dec4(6 + i)); fails++; end
         if (a_ready !== 1'b1) begin $display("FAIL b2b_ready %0d: got %b expected 1", i, a_ready); fails++; end
      end
      a_req = 0;
   endtask

   task automatic test_busy_abort();
      a_load(999);
      a_req = 1; a_set = 0; a_rev = 0;
      tick();
      a_req = 1; a_set = 1; a_in = dec4(1234);
      tick();
      a_req = 0; a_set = 0;
      $display("busy: out=%h ready=%b", a_out, a_ready);
      checks += 2;
      if (a_out !== dec4(900)) begin $display("FAIL busy_ignore: got %h expected %h", a_out, dec4(900)); fails++; end
      if (a_ready !== 1'b0) begin $display("FAIL busy_ready: got %b expected 0", a_ready); fails++; end
      rst_n = 0;
      tick();
      rst_n = 1;
      $display("abort: out=%h ready=%b ovf=%b", a_out, a_ready, a_ovf);
      checks += 3;
      if (a_out !== dec4(0)) begin $display("FAIL abort_out: got %h expected %h", a_out, dec4(0)); fails++; end
      if (a_ready !== 1'b1) begin $display("FAIL abort_ready: got %b expected 1", a_ready); fails++; end
      if (a_ovf !== 1'b0) begin $display("FAIL abort_ovf: got %b expected 0", a_ovf); fails++; end
      tick();
      checks++;
      if (a_out !== dec4(0)) begin $display("FAIL abort_hold: got %h expected %h", a_out, dec4(0)); fails++; end
   endtask

   initial begin
      tick();
      test_reset();
      test_ripple();
      test_full_wrap();
      test_octal();
      test_noripple();
      test_back_to_back();
      test_busy_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/dekatron_chain.md
Name: dekatron_chain

Overview:
- Multi-digit one-hot decade/octal counter built from parametrised dekatron-style digit stages.
- Each digit is a one-hot ring of RADIX positions, stepped forward or reverse, with inter-digit carry/borrow.
- Carry can ripple one digit per clock, modelling a tube carry chain, or resolve in the same cycle. A Ready handshake exposes the ripple latency.
- Sits under the address/data counter layer as the generalised replacement for single-digit Dekatron/Octotron counters.

Parameters:
- DIGITS, 4, number of cascaded digits (1..16); digit 0 is least significant.
- RADIX, 10, positions per digit (2..10); 10 = dekatron, 8 = octotron.
- RIPPLE, 1, 1 = carry advances one digit per clock; 0 = full carry resolved in the accepting cycle.

Ports:
- Clk, input, 1, rising-edge clock for all state.
- Rst_n, input, 1, synchronous active-low reset; one clock, no other clock or async inputs.
- Request, input, 1, operation request; accepted on a rising Clk edge when Request=1 and Ready=1.
- Set, input, 1, qualifies Request: 1 = load In, 0 = step.
- Reverse, input, 1, qualifies a step Request: 1 = -1, 0 = +1.
- In, input, DIGITS*10, load value; digit d occupies bits [10d+9:10d], one-hot.
- Out, output, DIGITS*10, current value, same packing; bits [10d+9:10d+RADIX] always 0.
- Ready, output, 1, 1 = idle and able to accept a Request.
- Zero, output, 1, combinational: 1 when every digit equals position 0.
- Overflow, output, 1, one-cycle pulse on top-digit wrap (carry or borrow out).

Behaviour:
- Reset (Rst_n=0 at a Clk edge)
  - Every digit is set to 10'b0000000001; Ready=1, Overflow=0, state=IDLE.
  - Reset overrides any request and aborts an in-progress carry.
- States: IDLE, CARRY. Internal regs: carry pointer ptr (clog2(DIGITS) bits) and latched direction dir.
- IDLE, Request & Set
  - Each digit loads In digit d if that digit is exactly one-hot with its set bit index < RADIX; otherwise the digit loads position 0.
  - Completes in 1 cycle; Ready stays 1; Overflow=0.
- IDLE, Request & ~Set: digit 0 rotates one position.
  - Forward: position RADIX-1 wraps to 0.
  - Reverse: position 0 wraps to RADIX-1.
  - No wrap: done; Ready stays 1.
  - Wrap with DIGITS=1: Overflow pulses.
  - Wrap, RIPPLE=1, DIGITS>1: latch dir=Reverse, ptr=1, go to CARRY; Ready=0 from the next cycle.
  - Wrap, RIPPLE=0: all digits that must change update on the same edge; Ready stays 1.
- CARRY, each clock
  - Digit[ptr] rotates in direction dir.
  - If it wraps and ptr<DIGITS-1: ptr increments; stay in CARRY.
  - If it wraps and ptr=DIGITS-1: Overflow pulses; return to IDLE.
  - If it does not wrap: return to IDLE.
- Ready timing
  - Ready is registered: 0 in every cycle the FSM is in CARRY, 1 otherwise.
  - A step causing k cascaded carries (k digits above digit 0 change) holds Ready=0 for exactly k cycles.
- Request while Ready=0 is ignored (not queued); Set, Reverse and In are don't-care then.
- Overflow timing
  - High for exactly the one cycle following the edge at which the top digit wrapped; 0 otherwise.
  - After a full wrap, Out is all position 0 (forward) or all RADIX-1 (reverse).
- Out is one-hot per digit at all times after reset; no transient multi-hot or zero-hot digit is ever visible.
- Zero is derived from Out only; it is valid in CARRY as the intermediate value.

Test Plan:
- Reset: DIGITS=4, RADIX=10, Rst_n=0 one edge -> Out=4×10'h001, Ready=1, Zero=1, Overflow=0.
- Ripple: load 0199, forward step -> edge1 digit0=0, Ready=0; edge2 digit1=0; edge3 digit2=2, Ready=1. Value 0200; Ready low exactly 2 cycles; Overflow never high.
- Full wrap: load 9999, forward step -> 0000 after 3 CARRY cycles, Overflow=1 for one cycle, Zero=1. Reverse step from 0000 -> 9999, Overflow one-cycle pulse.
- RADIX=8, DIGITS=2: load 77 octal, step -> 00 with Overflow. Load with digit0 bit 9 set -> digit0 reads 10'h001. Reverse from 00 -> 77.
- RIPPLE=0: load 0999, step -> 1000 on the same edge; Ready never deasserts.
- Busy/abort: during CARRY assert Request (Set=1, In=1234) -> ignored. Then Rst_n=0 mid-carry -> next edge Out=0000, Ready=1, Overflow=0.
